// File: rtl/alu_mp_pkg.sv
// Shared types and constants for the multi-precision ALU sequencer.
package alu_mp_pkg;

    // Multi-precision operation requested by the execute path.
    typedef enum logic [1:0] {
        MP_ADD = 2'd0,
        MP_SUB = 2'd1,
        MP_SHL = 2'd2,
        MP_SHR = 2'd3
    } mp_op_t;

    // Byte-ALU command encodings actually issued (SUB reuses ADD with inverted B).
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;
    localparam logic [2:0] ALU_SHR = 3'b010;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Initial value of the carry/shift chain for the first byte op.
    function automatic logic chain_init(input mp_op_t op, input logic shift_in);
        logic c;
        case (op)
            MP_ADD:  c = 1'b0;
            MP_SUB:  c = 1'b1;
            MP_SHL:  c = shift_in;
            MP_SHR:  c = shift_in;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mp_byte_sel.sv
// Picks the operand bytes for the current byte step. SHR walks from the
// top byte down, all other ops from byte 0 up; SUB feeds ~B to the adder.
module mp_byte_sel
    import alu_mp_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int IW     = $clog2(NBYTES)
) (
    input  logic [8*NBYTES-1:0] a_word,
    input  logic [8*NBYTES-1:0] b_word,
    input  logic [IW-1:0]       idx,
    input  mp_op_t              op,
    output logic [IW-1:0]       byte_idx,
    output logic [7:0]          a_byte,
    output logic [7:0]          b_byte
);

    logic [7:0] a_bytes_s [NBYTES];
    logic [7:0] b_bytes_s [NBYTES];

    for (genvar k = 0; k < NBYTES; k++) begin : g_split
        assign a_bytes_s[k] = a_word[8*k +: 8];
        assign b_bytes_s[k] = b_word[8*k +: 8];
    end

    // Map the step counter to a byte position and extract/condition the operands.
    always_comb begin
        byte_idx = idx;
        a_byte   = 8'h00;
        b_byte   = 8'h00;
        if (op == MP_SHR) begin
            byte_idx = IW'(NBYTES - 1) - idx;
        end else begin
            byte_idx = idx;
        end
        a_byte = a_bytes_s[byte_idx];
        if (op == MP_SUB) begin
            b_byte = ~b_bytes_s[byte_idx];
        end else begin
            b_byte = b_bytes_s[byte_idx];
        end
    end

endmodule

// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer: runs one NBYTES-wide ADD/SUB/SHL/SHR as a
// chain of byte ops through the shared 8-bit ALU, carrying the ALU
// carry/shift-out into the next byte.
module alu_mp_sequencer
    import alu_mp_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [8*NBYTES-1:0] a_in,
    input  logic [8*NBYTES-1:0] b_in,
    input  logic                shift_in,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                zero_out,
    output logic [2:0]          alu_cmd,
    output logic [7:0]          alu_ina,
    output logic [7:0]          alu_inb,
    output logic                alu_sc_i,
    input  logic [7:0]          alu_rslt,
    input  logic                alu_sc_o
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t         state_r;
    state_t         state_nx_s;
    logic [IW-1:0]  idx_r;
    mp_op_t         op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           chain_r;
    logic [W-1:0]   result_r;
    logic           carry_r;
    logic           zero_r;

    logic [IW-1:0]  byte_idx_s;
    logic [7:0]     a_byte_s;
    logic [7:0]     b_byte_s;
    logic [W-1:0]   result_wr_s;

    mp_byte_sel #(
        .NBYTES (NBYTES),
        .IW     (IW)
    ) u_byte_sel (
        .a_word   (a_r),
        .b_word   (b_r),
        .idx      (idx_r),
        .op       (op_r),
        .byte_idx (byte_idx_s),
        .a_byte   (a_byte_s),
        .b_byte   (b_byte_s)
    );

    // Result image with the byte currently leaving the ALU merged in.
    always_comb begin
        result_wr_s = result_r;
        for (int k = 0; k < NBYTES; k++) begin
            if (IW'(k) == byte_idx_s) begin
                result_wr_s[8*k +: 8] = alu_rslt;
            end else begin
                result_wr_s[8*k +: 8] = result_r[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and ALU drive; the ALU is only driven while running.
    always_comb begin
        state_nx_s = state_r;
        alu_cmd    = 3'b000;
        alu_ina    = 8'h00;
        alu_inb    = 8'h00;
        alu_sc_i   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                alu_ina  = a_byte_s;
                alu_sc_i = chain_r;
                case (op_r)
                    MP_SHL:  alu_cmd = ALU_SHL;
                    MP_SHR:  alu_cmd = ALU_SHR;
                    MP_ADD:  alu_cmd = ALU_ADD;
                    MP_SUB:  alu_cmd = ALU_ADD;
                    default: alu_cmd = ALU_ADD;
                endcase
                if ((op_r == MP_ADD) || (op_r == MP_SUB)) begin
                    alu_inb = b_byte_s;
                end else begin
                    alu_inb = 8'h00;
                end
                if (idx_r == LAST_IDX) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand latch, byte counter, carry chain and result/flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r    <= '0;
            op_r     <= MP_ADD;
            a_r      <= '0;
            b_r      <= '0;
            chain_r  <= 1'b0;
            result_r <= '0;
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= mp_op_t'(op);
                        a_r     <= a_in;
                        b_r     <= b_in;
                        idx_r   <= '0;
                        chain_r <= chain_init(mp_op_t'(op), shift_in);
                    end
                end
                RUN: begin
                    result_r <= result_wr_s;
                    chain_r  <= alu_sc_o;
                    if (idx_r == LAST_IDX) begin
                        idx_r   <= '0;
                        carry_r <= alu_sc_o;
                        zero_r  <= (result_wr_s == '0);
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign busy      = (state_r == RUN);
    assign done      = (state_r == DONE);
    assign result    = result_r;
    assign carry_out = carry_r;
    assign zero_out  = zero_r;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Randomised and directed bench for alu_mp_sequencer with an 8-bit byte ALU
// and a whole-word reference model.
module tb_alu_mp_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          shift_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          zero_out;
    logic [2:0]    alu_cmd;
    logic [7:0]    alu_ina;
    logic [7:0]    alu_inb;
    logic          alu_sc_i;
    logic [7:0]    alu_rslt;
    logic          alu_sc_o;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_cmd  = 0;
    int bad_idle = 0;

    alu_mp_sequencer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .shift_in  (shift_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .alu_cmd   (alu_cmd),
        .alu_ina   (alu_ina),
        .alu_inb   (alu_inb),
        .alu_sc_i  (alu_sc_i),
        .alu_rslt  (alu_rslt),
        .alu_sc_o  (alu_sc_o)
    );

    // 8-bit combinational ALU as seen by the sequencer.
    always_comb begin
        {alu_sc_o, alu_rslt} = 9'h000;
        case (alu_cmd)
            3'b000:  {alu_sc_o, alu_rslt} = {1'b0, alu_ina} + {1'b0, alu_inb} + {8'h00, alu_sc_i};
            3'b001:  {alu_sc_o, alu_rslt} = {alu_ina, alu_sc_i};
            3'b010:  {alu_rslt, alu_sc_o} = {alu_sc_i, alu_ina};
            default: {alu_sc_o, alu_rslt} = 9'h000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch the ALU interface for illegal commands and for drive while not busy.
    always @(negedge clk) begin
        if (reset_n) begin
            if (!(alu_cmd inside {3'b000, 3'b001, 3'b010})) bad_cmd++;
            if (!busy && ({alu_cmd, alu_ina, alu_inb, alu_sc_i} != 20'h0)) bad_idle++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference for one operation.
    task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic si, output logic [W-1:0] r, output logic c);
        logic [W:0] wide;
        case (o)
            2'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
            2'd1: begin r = a - b; c = (a >= b); end
            2'd2: begin r = {a[W-2:0], si}; c = a[W-1]; end
            default: begin r = {si, a[W-1:1]}; c = a[0]; end
        endcase
    endtask

    // Issue one op; optionally re-assert start during RUN and DONE with junk operands.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic si, input bit disturb);
        logic [W-1:0] er;
        logic         ec;
        int           first_done;
        int           n_done;
        ref_model(o, a, b, si, er, ec);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b; shift_in = si;
        first_done = -1;
        n_done = 0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = e;
            end
            if (e <= NBYTES) check_val("busy_run", {63'd0, busy}, 64'd1);
            if (e == NBYTES + 1) begin
                check_val("busy_done", {63'd0, busy}, 64'd0);
                check_val("result", {32'd0, result}, {32'd0, er});
                check_val("carry", {63'd0, carry_out}, {63'd0, ec});
                check_val("zero", {63'd0, zero_out}, {63'd0, (er == '0)});
            end
            @(negedge clk);
            start = 1'b0;
            if (disturb && (e == 2 || e == NBYTES + 1)) begin
                start = 1'b1;
                op = 2'($urandom_range(3, 0));
                a_in = $urandom();
                b_in = $urandom();
                shift_in = 1'($urandom_range(1, 0));
            end
        end
        check_val("done_latency", 64'(first_done), 64'(NBYTES + 1));
        check_val("done_pulses", 64'(n_done), 64'd1);
        check_val("result_held", {32'd0, result}, {32'd0, er});
    endtask

    initial begin
        logic [1:0] o;
        reset_n = 1'b0; start = 1'b0; op = 2'd0; a_in = '0; b_in = '0; shift_in = 1'b0;
        #12;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_result", {32'd0, result}, 64'd0);
        check_val("rst_flags", {62'd0, carry_out, zero_out}, 64'd0);
        check_val("rst_alu", {44'd0, alu_cmd, alu_ina, alu_inb, alu_sc_i}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_op(2'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        run_op(2'd2, 32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op(2'd3, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op(2'd3, 32'h0000_0001, 32'h1234_5678, 1'b0, 1'b0);

        // start re-asserted while RUN and while DONE must be ignored.
        run_op(2'd0, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1);
        run_op(2'd3, 32'hA5A5_5A5A, 32'h0, 1'b1, 1'b1);

        // Random ops.
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(3, 0));
            run_op(o, $urandom(), $urandom(), 1'($urandom_range(1, 0)), bit'($urandom_range(1, 0)));
        end

        // Reset in the second RUN cycle aborts the op.
        run_op(2'd0, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'd1; a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0001; shift_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        check_val("abort_result", {32'd0, result}, 64'd0);
        check_val("abort_flags", {62'd0, carry_out, zero_out}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_no_done", {63'd0, done}, 64'd0);
        run_op(2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(2'd1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);

        check_val("alu_cmd_legal", 64'(bad_cmd), 64'd0);
        check_val("alu_idle_quiet", 64'(bad_idle), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
